leaf_out_packetizer: RTL and testbench

- Parametrised output-side packetizer for a leaf shell; replaces the fixed 6-port user→BFT path with an N-channel generalisation.
- Accepts N user output streams (vld/ack handshake) and round-robin arbitrates among them.
- Forms one BFT packet per accepted word with a per-channel destination, a per-channel sequence number and credit-based flow control.
- Sits between the user kernel outputs and the BFT-facing packet port of the leaf, in the leaf clock domain.

---
 rtl/leaf_out_packetizer.sv | 122 ++++++++++++
 tb/tb_leaf_out_packetizer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_packetizer.sv
// Output-side leaf packetizer: round-robin arbitration over N user streams,
// credit-based flow control, per-channel sequence numbers, one BFT packet per word.
module leaf_out_packetizer #(
  parameter int unsigned NUM_OUT_PORTS = 6,
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_LEAF_BITS = 5,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned PACKET_BITS   = 49,
  parameter int unsigned CREDIT_BITS   = 8,
  parameter int unsigned INIT_CREDITS  = 128
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] dst_leaf_cfg,
  input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] dst_port_cfg,
  input  logic                                   credit_vld,
  input  logic [NUM_PORT_BITS-1:0]               credit_port,
  input  logic [CREDIT_BITS-1:0]                 credit_amt,
  input  logic                                   resend,
  input  logic                                   out_stall,
  output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft
);

  localparam int unsigned N        = NUM_OUT_PORTS;
  localparam int unsigned PTR_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CRED_MAX = (1 << CREDIT_BITS) - 1;

  logic [CREDIT_BITS-1:0]   credit_q [N];
  logic [CREDIT_BITS-1:0]   credit_d [N];
  logic [NUM_ADDR_BITS-1:0] seq_q    [N];
  logic [NUM_ADDR_BITS-1:0] seq_d    [N];
  logic [PTR_W-1:0]         last_q, last_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;

  logic [N-1:0]             eligible;
  logic                     grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [PACKET_BITS-1:0]   grant_pkt;

  // Eligibility and round-robin search starting after the last granted channel
  always_comb begin
    int unsigned cand;
    eligible  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < int'(N); i++) begin
      eligible[i] = vld_user2interface[i] && (credit_q[i] != '0) &&
                    !resend && !out_stall && !reset;
    end
    for (int k = 0; k < int'(N); k++) begin
      cand = (32'(last_q) + 32'(k) + 32'd1) % N;
      if (!grant_vld && eligible[PTR_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    ack_interface2user = '0;
    if (grant_vld) ack_interface2user[grant_idx] = 1'b1;
  end

  // Per-channel packet assembly, credit and sequence next-state
  always_comb begin
    logic [CREDIT_BITS:0] sum;
    logic                 hit;
    grant_pkt = '0;
    sum       = '0;
    hit       = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      hit = grant_vld && (grant_idx == PTR_W'(i));
      if (hit) begin
        grant_pkt = {1'b1,
                     dst_leaf_cfg[i*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                     dst_port_cfg[i*NUM_PORT_BITS +: NUM_PORT_BITS],
                     seq_q[i],
                     din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
      sum = {1'b0, credit_q[i]};
      if (credit_vld && (credit_port == NUM_PORT_BITS'(i))) sum = sum + {1'b0, credit_amt};
      // A granted channel always holds at least one credit, so this cannot underflow
      if (hit) sum = sum - (CREDIT_BITS+1)'(1);
      credit_d[i] = (32'(sum) > CRED_MAX) ? CREDIT_BITS'(CRED_MAX) : sum[CREDIT_BITS-1:0];
      seq_d[i]    = hit ? seq_q[i] + NUM_ADDR_BITS'(1) : seq_q[i];
    end
  end

  // Output register holds under stall or resend, otherwise loads the grant or clears
  always_comb begin
    dout_d = dout_q;
    last_d = last_q;
    if (!resend && !out_stall) dout_d = grant_vld ? grant_pkt : '0;
    if (grant_vld) last_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      last_q <= PTR_W'(N - 1);
      for (int i = 0; i < int'(N); i++) begin
        credit_q[i] <= CREDIT_BITS'(INIT_CREDITS);
        seq_q[i]    <= '0;
      end
    end else begin
      dout_q <= dout_d;
      last_q <= last_d;
      for (int i = 0; i < int'(N); i++) begin
        credit_q[i] <= credit_d[i];
        seq_q[i]    <= seq_d[i];
      end
    end
  end

  assign dout_leaf_interface2bft = resend ? '0 : dout_q;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Scoreboard bench for leaf_out_packetizer: reference model predicts acks and
// packets per cycle; a negedge monitor pops and compares.
module tb_leaf_out_packetizer;

  localparam int N   = 6;
  localparam int PB  = 32;
  localparam int LB  = 5;
  localparam int PTB = 4;
  localparam int AB  = 7;
  localparam int PKB = 49;
  localparam int CB  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*PB-1:0]   din;
  logic [N-1:0]      vld, ack;
  logic [N*LB-1:0]   dleaf;
  logic [N*PTB-1:0]  dport;
  logic              cv, rs, st;
  logic [PTB-1:0]    cp;
  logic [CB-1:0]     ca;
  logic [PKB-1:0]    dout;
  logic [PB-1:0]     data [N];

  typedef struct {
    logic [N-1:0]   ack;
    logic [PKB-1:0] dout;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int dut_acks [N];
  bit keep   = 1'b0;
  bit m_init = 1'b0;

  // Reference model state
  int             m_cred [N];
  int             m_seq  [N];
  int             m_last;
  logic [PKB-1:0] m_reg;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) din[i*PB +: PB] = data[i];
  end

  leaf_out_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dst_leaf_cfg            (dleaf),
    .dst_port_cfg            (dport),
    .credit_vld              (cv),
    .credit_port             (cp),
    .credit_amt              (ca),
    .resend                  (rs),
    .out_stall               (st),
    .dout_leaf_interface2bft (dout)
  );

  // Predict this cycle's response, queue it, then advance the model across the edge
  task automatic tick();
    int   g;
    int   c;
    int   n;
    exp_t e;
    g = -1;
    if (!reset && !rs && !st) begin
      for (int k = 0; k < N; k++) begin
        c = (m_last + 1 + k) % N;
        if (g < 0 && vld[c] && m_cred[c] > 0) g = c;
      end
    end
    e.ack = '0;
    if (g >= 0) e.ack[g] = 1'b1;
    e.dout = rs ? '0 : m_reg;
    if (m_init) q.push_back(e);
    if (reset) begin
      m_init = 1'b1;
      m_reg  = '0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) begin
        m_cred[i] = 128;
        m_seq[i]  = 0;
      end
    end else begin
      if (!rs && !st) begin
        if (g >= 0) m_reg = {1'b1, dleaf[g*LB +: LB], dport[g*PTB +: PTB], AB'(m_seq[g]), data[g]};
        else        m_reg = '0;
      end
      for (int i = 0; i < N; i++) begin
        n = m_cred[i];
        if (cv && int'(cp) == i) n = n + int'(ca);
        if (g == i) n = n - 1;
        if (n > 255) n = 255;
        m_cred[i] = n;
      end
      if (g >= 0) begin
        m_seq[g] = (m_seq[g] + 1) % (1 << AB);
        m_last   = g;
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (keep) data[g] = $urandom;
      else      vld[g]  = 1'b0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < N; i++) if (ack[i] === 1'b1) dut_acks[i]++;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (ack !== e.ack) begin
        bad++;
        $display("FAIL ack t=%0t got=%b want=%b", $time, ack, e.ack);
      end
      total++;
      if (dout !== e.dout) begin
        bad++;
        $display("FAIL dout t=%0t got=%h want=%h", $time, dout, e.dout);
      end
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  int a0;

  initial begin
    reset = 1'b1; vld = '0; rs = 1'b0; st = 1'b0;
    cv = 1'b0; cp = '0; ca = '0;
    for (int i = 0; i < N; i++) begin
      data[i] = '0;
      dut_acks[i] = 0;
      dleaf[i*LB +: LB]   = (i < 3) ? LB'(3)  : LB'(i + 7);
      dport[i*PTB +: PTB] = (i < 3) ? PTB'(1) : PTB'(i);
    end
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;

    // Three channels, one word each, served in index order
    data[0] = 32'hA0; data[1] = 32'hB1; data[2] = 32'hC2;
    vld = 6'b000111; keep = 1'b0;
    repeat (4) tick();
    check_int("first_acks_ch0", dut_acks[0], 1);
    check_int("first_acks_ch1", dut_acks[1], 1);
    check_int("first_acks_ch2", dut_acks[2], 1);

    // Credit exhaustion and recovery on ch4
    keep = 1'b1; vld = 6'b010000;
    repeat (130) tick();
    check_int("ch4_credit_limit", dut_acks[4], 128);
    cv = 1'b1; cp = 4'd4; ca = 8'd64;
    tick();
    cv = 1'b0;
    repeat (3) tick();
    check_int("ch4_resume", dut_acks[4], 131);
    vld = '0; tick();

    // Resend mutes output and blocks grants
    keep = 1'b0; vld[1] = 1'b1; rs = 1'b1;
    repeat (3) tick();
    check_int("resend_no_ack", dut_acks[1], 1);
    rs = 1'b0;
    tick(); tick();
    check_int("resend_release", dut_acks[1], 2);

    // Stall holds the registered packet
    vld[0] = 1'b1; tick();
    st = 1'b1; vld[3] = 1'b1;
    tick(); tick();
    check_int("stall_no_ack", dut_acks[3], 0);
    st = 1'b0;
    tick(); tick();
    check_int("stall_release", dut_acks[3], 1);

    // Credit saturation and out-of-range credit port
    cv = 1'b1; cp = 4'd0; ca = CB'(255 - m_cred[0]);
    tick();
    a0 = dut_acks[0];
    keep = 1'b1; vld = 6'b000001; ca = 8'd10;
    tick();
    cp = 4'd9; ca = 8'd50;
    tick();
    cv = 1'b0;
    repeat (260) tick();
    check_int("ch0_saturated_total", dut_acks[0] - a0, 256);
    vld = '0; tick();

    // Reset with a registered packet pending
    vld = 6'b000100; tick();
    reset = 1'b1; tick();
    reset = 1'b0; keep = 1'b0; vld = 6'b000111;
    a0 = dut_acks[0];
    tick();
    check_int("post_reset_first_ch0", dut_acks[0] - a0, 1);
    repeat (3) tick();

    // Randomised traffic
    keep = 1'b1;
    repeat (2000) begin
      vld   = N'($urandom);
      rs    = ($urandom % 16) == 0;
      st    = ($urandom % 8) == 0;
      cv    = ($urandom % 4) == 0;
      cp    = PTB'($urandom);
      ca    = (($urandom % 8) == 0) ? CB'($urandom) : CB'($urandom % 4);
      reset = ($urandom % 500) == 0;
      tick();
    end
    reset = 1'b0; vld = '0; rs = 1'b0; st = 1'b0; cv = 1'b0;
    repeat (3) tick();
    check_int("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
